watch_time_core: RTL
====================

# watch_time_core

Parametrised successor to the stopwatch/watch time datapath: a free-running time-of-day counter (sub-second/sec/min/hour) with its own tick prescaler, field-local up/down adjustment from buttons or UART, a 12/24-hour presentation mode, and an optional alarm comparator. It sits between the control unit, which supplies `field_sel` and debounced button pulses, the UART receiver and the FND/display formatter. Unlike the previous datapath, the carry chain resolves in a single cycle, adjustment never propagates borrow or carry into neighbouring fields, and ticks coinciding with an adjustment are never lost.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency; must be an integer multiple of `TICK_HZ`.
- `TICK_HZ`, 100, sub-second rate; the sub field counts 0..TICK_HZ-1; range 2..128.
- `INIT_HOUR`, 12, hour value after reset or after UART 'R' (0..23).
- `INIT_MIN`, 0, minute value after reset or after UART 'R'.
- `INIT_SEC`, 0, second value after reset or after UART 'R'; sub field always initialises to 0.
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `adj_up` input 1: one-cycle pulse; increments the selected field by one.
- `adj_down` input 1: one-cycle pulse; decrements the selected field by one.
- `uart_rx` input 8: received byte, valid when `uart_rx_done` is high.
- `uart_rx_done` input 1: one-cycle byte-valid strobe.
- `field_sel` input 2: 00 sub, 01 sec, 10 min, 11 hour.
- `mode_12h` input 1: 1 presents the hour as 1..12 on `hour_disp`.
- `alarm_hour` input 5, `alarm_min` input 6, `alarm_en` input 1: alarm setting; present only with `WATCH_ALARM_EN`.
- `msec` output 7: sub-second count.
- `sec` output 6, `min` output 6, `hour` output 5: time, with `hour` always 0..23.
- `hour_disp` output 5: `hour`, or its 12-hour form when `mode_12h` is high; combinational from `hour`.
- `pm` output 1: 1 when `hour` >= 12, in either mode.
- `sec_tick` output 1: one-cycle pulse when the sub field wraps from TICK_HZ-1 to 0 on a natural tick.
- `alarm_hit` output 1: one-cycle pulse; present only with `WATCH_ALARM_EN`.

## Operation
- Prescaler: counts 0..DIV-1 with DIV = CLK_HZ/TICK_HZ; `tick` asserts for one cycle when the prescaler is at DIV-1, and the prescaler then returns to 0. The prescaler never stops; there is no run/hold control.
- Natural tick: increments sub. If sub is at TICK_HZ-1, sub goes to 0 and sec increments, with the same rule applied up the chain through min (59) and hour (23 -> 0). The whole chain updates on the same clock edge.
- Adjust request: up = `adj_up` OR (`uart_rx_done` AND byte in {0x55, 0x75}); down = `adj_down` OR (`uart_rx_done` AND byte in {0x44, 0x64}). Button and UART requests in the same direction in the same cycle produce one step. Up and down together cancel, and no step occurs.
- Adjust applies only to the field selected by `field_sel` and wraps within that field (59 -> 0, 0 -> 59, 23 -> 0, 0 -> 23, TICK_HZ-1 -> 0). It never carries or borrows into another field and never pulses `sec_tick`.
- Tick/adjust collision: when a step and `tick` occur in the same cycle, the step is applied and a 1-bit `tick_pend` is set. The pending tick is applied on the next cycle in which no step occurs; because DIV >= 2, it is always applied before the next tick.
- UART byte 0x52 or 0x72 ('R'/'r') loads the INIT_* values, sets sub to 0, clears `tick_pend` and leaves the prescaler running. This load has priority over all steps and ticks in that cycle. All other bytes are ignored.
- 12-hour mapping: 0 -> 12, 1..12 -> unchanged, 13..23 -> hour-12.
- Width rules: the sub field width is 7 bits. Counters compare against their exact terminal values, and out-of-range values cannot be reached.

## Timing
- Reset values: `msec`=0, `sec`=INIT_SEC, `min`=INIT_MIN, `hour`=INIT_HOUR, prescaler 0, `tick_pend` 0, `sec_tick` 0, `alarm_hit` 0.
- The time fields are registered. A step or UART command sampled at edge n is visible on the outputs after edge n.
- `sec_tick` is registered and high in the cycle after the sec field update, for exactly one cycle.
- Asserting `rst` mid-operation clears everything immediately, with no dependence on the clock edge. The first tick after release occurs DIV cycles later.

## Configuration
- `WATCH_ALARM_EN` defined: the alarm ports exist. `alarm_hit` pulses for one cycle, registered one cycle after a natural tick makes hour==`alarm_hour`, min==`alarm_min`, sec==0 and sub==0 while `alarm_en`=1. Steps or an 'R' command that reach that value do not fire the alarm.
- `WATCH_ALARM_EN` undefined: the alarm ports and comparator are absent, with no residual logic.

## Test plan
- CLK_HZ=1000, TICK_HZ=100, INIT 23:59:59, sub preset to 99 by steps, then wait for `tick` -> all fields 0 on the same edge, and `sec_tick` pulses once.
- `field_sel`=01, sec=0, `adj_down` pulse -> sec=59, min unchanged; at sec=59, `adj_up` -> sec=0, min unchanged.
- `adj_up` and UART 'u' in the same cycle -> single increment; `adj_up` and `adj_down` together -> no change.
- Step issued exactly on a `tick` cycle with sub=10 and `field_sel`=00 -> sub=11, then 12 on the next cycle, and no tick is lost over 1000 cycles.
- UART 'R' mid-count at 05:06:07 -> 12:00:00.00, prescaler phase preserved; 'x' -> no change.
- `WATCH_ALARM_EN`, alarm 00:00, `alarm_en`=1, natural rollover from 23:59:59.99 -> `alarm_hit` for one cycle; reaching 00:00 by hour steps -> no pulse.

Source files
------------

// File: rtl/watch_time_core.sv
// Time-of-day counter (sub/sec/min/hour) with a built-in tick prescaler, per-field wrap adjust,
// a deferred tick that survives adjust collisions, and 12/24 h display. Alarm: WATCH_ALARM_EN.
module watch_time_core #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned INIT_HOUR = 12,
    parameter int unsigned INIT_MIN  = 0,
    parameter int unsigned INIT_SEC  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adj_up,
    input  logic       adj_down,
    input  logic [7:0] uart_rx,
    input  logic       uart_rx_done,
    input  logic [1:0] field_sel,
    input  logic       mode_12h,
`ifdef WATCH_ALARM_EN
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_en,
    output logic       alarm_hit,
`endif
    output logic [6:0] msec,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [4:0] hour_disp,
    output logic       pm,
    output logic       sec_tick
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [6:0]    SUB_MAX   = 7'(TICK_HZ - 1);
    localparam logic [5:0]    SEC_INIT  = 6'(INIT_SEC);
    localparam logic [5:0]    MIN_INIT  = 6'(INIT_MIN);
    localparam logic [4:0]    HOUR_INIT = 5'(INIT_HOUR);

    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    sub_q, sub_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic          pend_q, pend_d;
    logic          sec_tick_q, sec_tick_d;

    logic tick, load, up_req, down_req, step, advance;

    // Wrap a field value by one in either direction, independent of its neighbours.
    function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] max,
                                             input logic up);
        if (up) begin
            return (v == max) ? 7'd0 : v + 7'd1;
        end
        return (v == 7'd0) ? max : v - 7'd1;
    endfunction

    assign tick     = (presc_q == PRESC_MAX);
    assign load     = uart_rx_done && (uart_rx == 8'h52 || uart_rx == 8'h72);
    assign up_req   = adj_up   || (uart_rx_done && (uart_rx == 8'h55 || uart_rx == 8'h75));
    assign down_req = adj_down || (uart_rx_done && (uart_rx == 8'h44 || uart_rx == 8'h64));
    assign step     = up_req ^ down_req;

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        sub_d   = sub_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        pend_d  = pend_q;
        advance = 1'b0;
        if (load) begin
            sub_d  = 7'd0;
            sec_d  = SEC_INIT;
            min_d  = MIN_INIT;
            hour_d = HOUR_INIT;
            pend_d = 1'b0;
        end else if (step) begin
            // A tick landing on an adjust cycle is deferred, not dropped.
            pend_d = pend_q | tick;
            unique case (field_sel)
                2'b00: sub_d  = wrap_step(sub_q, SUB_MAX, up_req);
                2'b01: sec_d  = 6'(wrap_step({1'b0, sec_q}, 7'd59, up_req));
                2'b10: min_d  = 6'(wrap_step({1'b0, min_q}, 7'd59, up_req));
                2'b11: hour_d = 5'(wrap_step({2'b00, hour_q}, 7'd23, up_req));
            endcase
        end else if (tick || pend_q) begin
            advance = 1'b1;
            pend_d  = tick & pend_q;
            if (sub_q == SUB_MAX) begin
                sub_d = 7'd0;
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == 6'd59) begin
                        min_d  = 6'd0;
                        hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                sub_d = sub_q + 7'd1;
            end
        end
    end

    assign sec_tick_d = advance && (sub_q == SUB_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            sub_q      <= 7'd0;
            sec_q      <= SEC_INIT;
            min_q      <= MIN_INIT;
            hour_q     <= HOUR_INIT;
            pend_q     <= 1'b0;
            sec_tick_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sub_q      <= sub_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            pend_q     <= pend_d;
            sec_tick_q <= sec_tick_d;
        end
    end

`ifdef WATCH_ALARM_EN
    logic alarm_hit_q, alarm_hit_d;

    // Only a natural advance can fire the alarm; adjusts and loads never do.
    always_comb begin
        alarm_hit_d = advance && alarm_en && (hour_d == alarm_hour) && (min_d == alarm_min) &&
                      (sec_d == 6'd0) && (sub_d == 7'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_hit_q <= 1'b0;
        end else begin
            alarm_hit_q <= alarm_hit_d;
        end
    end

    assign alarm_hit = alarm_hit_q;
`endif

    always_comb begin
        hour_disp = hour_q;
        if (mode_12h) begin
            if (hour_q == 5'd0) begin
                hour_disp = 5'd12;
            end else if (hour_q > 5'd12) begin
                hour_disp = hour_q - 5'd12;
            end
        end
    end

    assign msec     = sub_q;
    assign sec      = sec_q;
    assign min      = min_q;
    assign hour     = hour_q;
    assign pm       = (hour_q >= 5'd12);
    assign sec_tick = sec_tick_q;

endmodule
